ntt_core_rdx_cut_seq: RTL

Runtime-configurable radix-cut sequencer for the NTT core. It generalises the fixed two-column radix cut (negacyclic log-radix 5, cyclic log-radix 6) to up to RDX_CUT_NB_MAX columns, with per-column log-radix, polynomial count and batch size chosen at run time. The block sits in front of the NTT butterfly datapath. It emits one control beat per cycle naming column, stage, polynomial and beat index, and it validates the cut configuration before starting.

---
 rtl/ntt_core_rdx_cut_seq.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ntt_core_rdx_cut_seq.sv
`default_nettype none
// ============================================================================
// Module   : ntt_core_rdx_cut_seq
// Purpose  : Runtime-configurable radix-cut sequencer. Validates a cut
//            configuration on start, then emits one control beat per
//            handshake: column -> local stage -> polynomial -> beat.
// Revision : 1.0 - initial release
// ============================================================================
module ntt_core_rdx_cut_seq #(
    parameter int RDX_CUT_NB_MAX = 4,
    parameter int LOG_N_MAX      = 11,
    parameter int LOG_PSI        = 3,
    parameter int BATCH_W        = 4,
    parameter int NGC_S_MAX      = 5,
    parameter int CYC_S_MAX      = 6,
    localparam int NB_W          = $clog2(RDX_CUT_NB_MAX + 1),
    localparam int COL_W         = $clog2(RDX_CUT_NB_MAX),
    localparam int GSTG_W        = $clog2(LOG_N_MAX),
    localparam int BEAT_W        = LOG_N_MAX - 1 - LOG_PSI
) (
    input  logic                        clk,
    input  logic                        a_rst,
    input  logic                        start,
    input  logic [NB_W-1:0]             cfg_cut_nb,
    input  logic [RDX_CUT_NB_MAX*3-1:0] cfg_cut_s,
    input  logic [BATCH_W-1:0]          cfg_batch,
    output logic                        busy,
    output logic                        done,
    output logic                        cfg_err,
    output logic                        out_vld,
    input  logic                        out_rdy,
    output logic [COL_W-1:0]            out_col,
    output logic [2:0]                  out_lstg,
    output logic [GSTG_W-1:0]           out_gstg,
    output logic [BATCH_W-1:0]          out_pbs,
    output logic [BEAT_W-1:0]           out_beat,
    output logic                        out_ngc,
    output logic                        out_sol,
    output logic                        out_eol,
    output logic                        out_last
);

    // Wide enough to hold the sum of every column at its 3-bit maximum.
    localparam int SUM_W = $clog2(RDX_CUT_NB_MAX * 7 + 1) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    logic [1:0]                  r_state;
    logic [1:0]                  w_state_nxt;

    logic [NB_W-1:0]             r_nb;
    logic [RDX_CUT_NB_MAX*3-1:0] r_cut_s;
    logic [BATCH_W-1:0]          r_batch;
    logic [BEAT_W-1:0]           r_beat_max;

    logic [COL_W-1:0]            r_col;
    logic [2:0]                  r_lstg;
    logic [GSTG_W-1:0]           r_gstg;
    logic [BATCH_W-1:0]          r_pbs;
    logic [BEAT_W-1:0]           r_beat;
    logic                        r_vld;
    logic                        r_ngc;
    logic                        r_sol;
    logic                        r_eol;
    logic                        r_last;
    logic                        r_done;

    logic                        w_cfg_ok;
    logic [SUM_W-1:0]            w_log_n;
    logic [SUM_W-1:0]            w_shift;
    logic [BEAT_W-1:0]           w_beat_max_in;

    logic                        w_load;
    logic                        w_fire;
    logic                        w_fin;

    logic [NB_W-1:0]             w_sel_nb;
    logic [RDX_CUT_NB_MAX*3-1:0] w_sel_cut_s;
    logic [BATCH_W-1:0]          w_sel_batch;
    logic [BEAT_W-1:0]           w_sel_beat_max;

    logic [2:0]                  w_cur_s;
    logic                        w_beat_wrap;
    logic                        w_pbs_wrap;
    logic                        w_lstg_wrap;

    logic [COL_W-1:0]            w_nx_col;
    logic [2:0]                  w_nx_lstg;
    logic [GSTG_W-1:0]           w_nx_gstg;
    logic [BATCH_W-1:0]          w_nx_pbs;
    logic [BEAT_W-1:0]           w_nx_beat;
    logic [2:0]                  w_nx_s;
    logic                        w_nx_sol;
    logic                        w_nx_eol;
    logic                        w_nx_last;

    // Legality of the configuration currently presented on cfg_* and the
    // resulting beat limit; logN is summed at full width so no overflow hides.
    always_comb begin
        w_cfg_ok = (int'(cfg_cut_nb) >= 1) && (int'(cfg_cut_nb) <= RDX_CUT_NB_MAX);
        w_log_n  = '0;
        for (int i = 0; i < RDX_CUT_NB_MAX; i++) begin
            if (i < int'(cfg_cut_nb)) begin
                w_log_n = w_log_n + SUM_W'(cfg_cut_s[3*i +: 3]);
                if (cfg_cut_s[3*i +: 3] == 3'd0) begin
                    w_cfg_ok = 1'b0;
                end
                if ((i == 0) && (int'(cfg_cut_s[3*i +: 3]) > NGC_S_MAX)) begin
                    w_cfg_ok = 1'b0;
                end
                if ((i != 0) && (int'(cfg_cut_s[3*i +: 3]) > CYC_S_MAX)) begin
                    w_cfg_ok = 1'b0;
                end
            end
        end
        if ((int'(w_log_n) < LOG_PSI + 1) || (int'(w_log_n) > LOG_N_MAX)) begin
            w_cfg_ok = 1'b0;
        end
        w_shift       = w_log_n - SUM_W'(LOG_PSI + 1);
        w_beat_max_in = BEAT_W'((32'd1 << w_shift) - 32'd1);
    end

    // State register.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: a start is only honoured from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = w_cfg_ok ? S_RUN : S_ERR;
            S_RUN:   if (r_vld && out_rdy && r_last) w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM strobes: configuration load, beat acceptance and sequence end.
    always_comb begin
        w_load = (r_state == S_IDLE) && start && w_cfg_ok;
        w_fire = (r_state == S_RUN) && r_vld && out_rdy;
        w_fin  = w_fire && r_last;
    end

    // Next beat: either the first beat of a freshly loaded configuration or
    // the nested-counter advance. Flags are derived from the next counters so
    // they can be registered alongside them.
    always_comb begin
        w_sel_nb       = w_load ? cfg_cut_nb    : r_nb;
        w_sel_cut_s    = w_load ? cfg_cut_s     : r_cut_s;
        w_sel_batch    = w_load ? cfg_batch     : r_batch;
        w_sel_beat_max = w_load ? w_beat_max_in : r_beat_max;

        w_cur_s     = r_cut_s[3*r_col +: 3];
        w_beat_wrap = (r_beat == r_beat_max);
        w_pbs_wrap  = (r_pbs == r_batch);
        w_lstg_wrap = (r_lstg == w_cur_s - 3'd1);

        if (w_load) begin
            w_nx_col  = '0;
            w_nx_lstg = '0;
            w_nx_gstg = '0;
            w_nx_pbs  = '0;
            w_nx_beat = '0;
        end else begin
            w_nx_col  = r_col;
            w_nx_lstg = r_lstg;
            w_nx_gstg = r_gstg;
            w_nx_pbs  = r_pbs;
            w_nx_beat = w_beat_wrap ? '0 : r_beat + BEAT_W'(1);
            if (w_beat_wrap) begin
                w_nx_pbs = w_pbs_wrap ? '0 : r_pbs + BATCH_W'(1);
                if (w_pbs_wrap) begin
                    w_nx_gstg = r_gstg + GSTG_W'(1);
                    w_nx_lstg = w_lstg_wrap ? '0 : r_lstg + 3'd1;
                    if (w_lstg_wrap) begin
                        w_nx_col = r_col + COL_W'(1);
                    end
                end
            end
        end

        w_nx_s    = w_sel_cut_s[3*w_nx_col +: 3];
        w_nx_sol  = (w_nx_lstg == 3'd0) && (w_nx_pbs == '0) && (w_nx_beat == '0);
        w_nx_eol  = (w_nx_lstg == w_nx_s - 3'd1) && (w_nx_pbs == w_sel_batch)
                    && (w_nx_beat == w_sel_beat_max);
        w_nx_last = w_nx_eol && (NB_W'(w_nx_col) == w_sel_nb - NB_W'(1));
    end

    // Configuration capture, beat counters and registered beat outputs.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            r_nb       <= '0;
            r_cut_s    <= '0;
            r_batch    <= '0;
            r_beat_max <= '0;
            r_col      <= '0;
            r_lstg     <= '0;
            r_gstg     <= '0;
            r_pbs      <= '0;
            r_beat     <= '0;
            r_vld      <= 1'b0;
            r_ngc      <= 1'b0;
            r_sol      <= 1'b0;
            r_eol      <= 1'b0;
            r_last     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_fin;
            if (w_load) begin
                r_nb       <= cfg_cut_nb;
                r_cut_s    <= cfg_cut_s;
                r_batch    <= cfg_batch;
                r_beat_max <= w_beat_max_in;
            end
            if (w_load || (w_fire && !r_last)) begin
                r_col  <= w_nx_col;
                r_lstg <= w_nx_lstg;
                r_gstg <= w_nx_gstg;
                r_pbs  <= w_nx_pbs;
                r_beat <= w_nx_beat;
                r_vld  <= 1'b1;
                r_ngc  <= (w_nx_col == '0);
                r_sol  <= w_nx_sol;
                r_eol  <= w_nx_eol;
                r_last <= w_nx_last;
            end else if (w_fin) begin
                r_col  <= '0;
                r_lstg <= '0;
                r_gstg <= '0;
                r_pbs  <= '0;
                r_beat <= '0;
                r_vld  <= 1'b0;
                r_ngc  <= 1'b0;
                r_sol  <= 1'b0;
                r_eol  <= 1'b0;
                r_last <= 1'b0;
            end
        end
    end

    assign busy     = (r_state == S_RUN);
    assign cfg_err  = (r_state == S_ERR);
    assign done     = r_done;
    assign out_vld  = r_vld;
    assign out_col  = r_col;
    assign out_lstg = r_lstg;
    assign out_gstg = r_gstg;
    assign out_pbs  = r_pbs;
    assign out_beat = r_beat;
    assign out_ngc  = r_ngc;
    assign out_sol  = r_sol;
    assign out_eol  = r_eol;
    assign out_last = r_last;

endmodule
`default_nettype wire
